// File: rtl/led_mmio.sv
// Memory-mapped LED peripheral: 5-word register window, pattern register and an
// autonomous rotation engine. Defining LED_MMIO_PWM_EN adds the LED_DUTY dimmer.
module led_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0030,
    parameter int          N_LEDS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbe,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic [N_LEDS-1:0] leds,
    output logic              dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } rot_state_t;

    localparam logic [2:0] IDX_DATA   = 3'd0;
    localparam logic [2:0] IDX_CTRL   = 3'd1;
    localparam logic [2:0] IDX_PERIOD = 3'd2;
    localparam logic [2:0] IDX_COUNT  = 3'd3;
    localparam logic [2:0] IDX_DUTY   = 3'd4;

    rot_state_t        r_state;
    rot_state_t        w_state_nxt;
    logic [N_LEDS-1:0] r_led_data;
    logic [1:0]        r_ctrl;
    logic [31:0]       r_period;
    logic [31:0]       r_rot_count;
    logic [31:0]       r_tick_cnt;
    logic [31:0]       r_rdata;
    logic [N_LEDS-1:0] r_leds;

    logic [29:0]         w_word_off;
    logic                w_hit;
    logic [2:0]          w_idx;
    logic                w_wr_data;
    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_count;
    logic                w_stop;
    logic                w_tick;
    logic [31:0]         w_cnt_nxt;
    logic [31:0]         w_period_last;
    logic [2*N_LEDS-1:0] w_dd;
    logic [N_LEDS-1:0]   w_rot;
    logic [N_LEDS-1:0]   w_led_nxt;
    logic [N_LEDS-1:0]   w_leds_nxt;
    logic [31:0]         w_led_ext;
    logic [31:0]         w_duty_rd;
    logic [31:0]         w_rd_val;
    logic                w_unused;

    // The window starts at BASE_ADDR itself, so decode by word offset from the base;
    // the window may straddle a 32-byte boundary. Byte-lane bits are ignored.
    assign w_word_off = addr[31:2] - BASE_ADDR[31:2];
    assign w_hit      = (w_word_off < 30'd5);
    assign w_idx      = w_word_off[2:0];
    assign w_unused   = &{1'b0, addr[1:0]};

    assign w_wr_data   = we && w_hit && (w_idx == IDX_DATA) && wbe[0];
    assign w_wr_ctrl   = we && w_hit && (w_idx == IDX_CTRL) && wbe[0];
    assign w_wr_period = we && w_hit && (w_idx == IDX_PERIOD) && (wbe != 4'b0000);
    assign w_wr_count  = we && w_hit && (w_idx == IDX_COUNT);
    assign w_stop      = w_wr_ctrl && !wdata[0];

    // A stored period of 0 runs at the same rate as 1.
    assign w_period_last = (r_period == 32'd0) ? 32'd0 : (r_period - 32'd1);

    assign w_dd  = {r_led_data, r_led_data};
    assign w_rot = r_ctrl[1] ? w_dd[N_LEDS -: N_LEDS] : w_dd[2*N_LEDS-2 -: N_LEDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_tick_cnt;
        w_tick      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_ctrl && wdata[0]) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 32'd0;
                end else if (w_wr_period) begin
                    w_cnt_nxt = 32'd0;
                end
            end
            S_RUN: begin
                // Stopping freezes pattern and counter; a period change restarts the count.
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wr_period) begin
                    w_cnt_nxt = 32'd0;
                end else if (r_tick_cnt == w_period_last) begin
                    w_tick    = 1'b1;
                    w_cnt_nxt = 32'd0;
                end else begin
                    w_cnt_nxt = r_tick_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    // A store to LED_DATA on a tick cycle takes priority over the rotation.
    assign w_led_nxt = w_wr_data ? wdata[N_LEDS-1:0] : (w_tick ? w_rot : r_led_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_data  <= '0;
            r_ctrl      <= 2'b00;
            r_period    <= 32'd1;
            r_rot_count <= 32'd0;
        end else begin
            r_led_data <= w_led_nxt;
            if (w_wr_ctrl) begin
                r_ctrl <= wdata[1:0];
            end
            if (w_wr_period) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbe[b]) begin
                        r_period[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (w_wr_count) begin
                r_rot_count <= 32'd0;
            end else if (w_tick && !w_wr_data) begin
                r_rot_count <= r_rot_count + 32'd1;
            end
        end
    end

`ifdef LED_MMIO_PWM_EN
    logic [7:0] r_duty;
    logic [7:0] r_pwm_cnt;
    logic       w_wr_duty;
    logic       w_pwm_on;

    assign w_wr_duty = we && w_hit && (w_idx == IDX_DUTY) && wbe[0];
    assign w_pwm_on  = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty    <= 8'hFF;
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_wr_duty) begin
                r_duty <= wdata[7:0];
            end
        end
    end

    assign w_leds_nxt = w_led_nxt & {N_LEDS{w_pwm_on}};
    assign w_duty_rd  = {24'd0, r_duty};
`else
    assign w_leds_nxt = w_led_nxt;
    assign w_duty_rd  = 32'd0;
`endif

    always_comb begin
        w_led_ext               = 32'd0;
        w_led_ext[N_LEDS-1:0]   = r_led_data;
        w_rd_val                = 32'd0;
        if (w_hit) begin
            case (w_idx)
                IDX_DATA:   w_rd_val = w_led_ext;
                IDX_CTRL:   w_rd_val = {30'd0, r_ctrl};
                IDX_PERIOD: w_rd_val = r_period;
                IDX_COUNT:  w_rd_val = r_rot_count;
                IDX_DUTY:   w_rd_val = w_duty_rd;
                default:    w_rd_val = 32'd0;
            endcase
        end
    end

    // Loads capture the pre-store register values, so a same-cycle store is not visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_leds  <= '0;
        end else begin
            if (re) begin
                r_rdata <= w_rd_val;
            end
            r_leds <= w_leds_nxt;
        end
    end

    assign rdata     = r_rdata;
    assign leds      = r_leds;
    assign dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_led_mmio.sv
// Bench for led_mmio: directed register/rotation steps, then random bus traffic
// compared every cycle against a register-level reference model.
module tb_led_mmio;
  localparam logic [31:0] BASE = 32'h8000_0030;
  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [N-1:0] leds;
  logic        dbg_state;

  led_mmio #(.BASE_ADDR(BASE), .N_LEDS(N)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wbe(wbe),
    .we(we), .re(re), .rdata(rdata), .leds(leds), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: architectural registers plus cycles elapsed in the current period
  logic [N-1:0] m_data;
  logic [N-1:0] m_leds;
  logic         m_en;
  logic         m_dir;
  logic [31:0]  m_period;
  logic [31:0]  m_count;
  logic [31:0]  m_phase;
  logic [31:0]  m_rdata;
`ifdef LED_MMIO_PWM_EN
  logic [7:0]   m_duty;
  logic [7:0]   m_pwm;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_leds = '0; m_en = 1'b0; m_dir = 1'b0;
    m_period = 32'd1; m_count = 32'd0; m_phase = 32'd0; m_rdata = 32'd0;
`ifdef LED_MMIO_PWM_EN
    m_duty = 8'hFF; m_pwm = 8'd0;
`endif
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    logic [31:0] wa, lo, rv, p;
    int idx;
    logic dw, cw, pw, kw, on;
    wa = a >> 2;
    lo = BASE >> 2;
    idx = ((wa >= lo) && (wa <= lo + 32'd4)) ? int'(wa - lo) : -1;
    case (idx)
      0: rv = 32'(m_data);
      1: rv = {30'd0, m_dir, m_en};
      2: rv = m_period;
      3: rv = m_count;
`ifdef LED_MMIO_PWM_EN
      4: rv = {24'd0, m_duty};
`endif
      default: rv = 32'd0;
    endcase
    dw = w && (idx == 0) && be[0];
    cw = w && (idx == 1) && be[0];
    pw = w && (idx == 2) && (be != 4'b0000);
    kw = w && (idx == 3);
    on = 1'b1;
`ifdef LED_MMIO_PWM_EN
    on = (m_duty == 8'hFF) || (m_pwm < m_duty);
`endif
    p = (m_period == 32'd0) ? 32'd1 : m_period;
    if (m_en && !(cw && !d[0]) && !pw) begin
      if (m_phase + 32'd1 == p) begin
        m_phase = 32'd0;
        if (!dw) begin
          if (m_dir) m_data = (m_data >> 1) | (m_data << (N - 1));
          else       m_data = (m_data << 1) | (m_data >> (N - 1));
          m_count = m_count + 32'd1;
        end
      end else begin
        m_phase = m_phase + 32'd1;
      end
    end
    if (dw) m_data = d[N-1:0];
    if (cw) begin
      if (!m_en && d[0]) m_phase = 32'd0;
      m_en = d[0];
      m_dir = d[1];
    end
    if (pw) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_period[8*b +: 8] = d[8*b +: 8];
      m_phase = 32'd0;
    end
    if (kw) m_count = 32'd0;
`ifdef LED_MMIO_PWM_EN
    if (w && (idx == 4) && be[0]) m_duty = d[7:0];
    m_pwm = m_pwm + 8'd1;
`endif
    if (r) m_rdata = rv;
    m_leds = on ? m_data : '0;
  endtask

  // driver tasks: one bus cycle per call, outputs checked 1 ns after the edge
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    we = w; re = r; addr = a; wdata = d; wbe = be;
    @(posedge clk);
    model_edge(w, r, a, d, be);
    #1;
    we = 1'b0; re = 1'b0; wbe = 4'b0000;
    check("leds", 32'(leds), 32'(m_leds));
    check("rdata", rdata, m_rdata);
    check("state", 32'(dbg_state), 32'(m_en));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, a, 32'd0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  initial begin
    logic [3:0] exp_rot[4];
    logic [3:0] prev_rot;
    int on_cnt;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0; wbe = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    rd(BASE + 32'h08); check("rst_period", rdata, 32'd1);
    rd(BASE + 32'h0C); check("rst_count", rdata, 32'd0);
    wr(BASE, 32'h1);   check("wr_leds", 32'(leds), 32'h1);
    rd(BASE);          check("rd_data", rdata, 32'h1);
    rd(BASE + 32'h3);  check("rd_lane_ignored", rdata, 32'h1);
    rd(BASE + 32'h14); check("miss_hi", rdata, 32'd0);
    rd(BASE - 32'h4);  check("miss_lo", rdata, 32'd0);
    wr(BASE + 32'h14, 32'hF);
    step(1'b1, 1'b0, BASE, 32'hF, 4'b1110);
    check("no_wbe0", 32'(leds), 32'h1);

    // left rotation, period 10
    exp_rot[0] = 4'b0010; exp_rot[1] = 4'b0100; exp_rot[2] = 4'b1000; exp_rot[3] = 4'b0001;
    prev_rot = 4'b0001;
    wr(BASE + 32'h08, 32'd10);
    wr(BASE + 32'h04, 32'h1);
    for (int k = 0; k < 4; k++) begin
      idle(9); check("rot_hold", 32'(leds), 32'(prev_rot));
      idle(1); check("rot_step", 32'(leds), 32'(exp_rot[k]));
      prev_rot = exp_rot[k];
    end
    rd(BASE + 32'h0C); check("rot_count4", rdata, 32'd4);
    step(1'b1, 1'b1, BASE + 32'h08, 32'd3, 4'hF);
    check("rw_old_value", rdata, 32'd10);
    wr(BASE + 32'h04, 32'h0);
    wr(BASE + 32'h0C, 32'h0);
    rd(BASE + 32'h0C); check("count_cleared", rdata, 32'd0);

    // right rotation, period 0 acts as 1
    wr(BASE, 32'h1);
    wr(BASE + 32'h08, 32'd0);
    wr(BASE + 32'h04, 32'h3);
    idle(1); check("dir_r1", 32'(leds), 32'h8);
    idle(1); check("dir_r2", 32'(leds), 32'h4);
    idle(1); check("dir_r3", 32'(leds), 32'h2);
    idle(1); check("dir_r4", 32'(leds), 32'h1);
    wr(BASE + 32'h04, 32'h0);

    // LED_DATA store landing on the tick, then ROT_COUNT clear on a tick
    wr(BASE + 32'h0C, 32'h0);
    wr(BASE, 32'h1);
    wr(BASE + 32'h08, 32'd5);
    wr(BASE + 32'h04, 32'h1);
    idle(4); check("tick_pre", 32'(leds), 32'h1);
    wr(BASE, 32'h5); check("tick_wr_wins", 32'(leds), 32'h5);
    idle(4); check("tick_after", 32'(leds), 32'h5);
    idle(1); check("tick_next", 32'(leds), 32'hA);
    rd(BASE + 32'h0C); check("tick_count", rdata, 32'd1);
    idle(3);
    wr(BASE + 32'h0C, 32'h0); check("clr_tick_leds", 32'(leds), 32'h5);
    rd(BASE + 32'h0C); check("clr_wins", rdata, 32'd0);

    // asynchronous reset while rotating
    rd(BASE + 32'h08); check("pre_rst_period", rdata, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async_leds", 32'(leds), 32'd0);
    check("async_rdata", rdata, 32'd0);
    check("async_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rd(BASE + 32'h08); check("post_rst_period", rdata, 32'd1);

`ifdef LED_MMIO_PWM_EN
    rd(BASE + 32'h10); check("duty_rst", rdata, 32'hFF);
    wr(BASE, 32'hF);
    wr(BASE + 32'h10, 32'd64);
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      idle(1);
      if (leds == 4'hF) on_cnt++;
    end
    check("pwm64", 32'(on_cnt), 32'd64);
    rd(BASE); check("pwm_rd_ungated", rdata, 32'hF);
    wr(BASE + 32'h10, 32'd0);
    idle(1);
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      idle(1);
      if (leds != 4'h0) on_cnt++;
    end
    check("pwm0", 32'(on_cnt), 32'd0);
    wr(BASE + 32'h10, 32'hFF);
`else
    rd(BASE + 32'h10); check("duty_absent", rdata, 32'd0);
    wr(BASE + 32'h10, 32'hFF);
    rd(BASE + 32'h10); check("duty_ignored", rdata, 32'd0);
    on_cnt = 0;
`endif

    // random traffic against the model
    wr(BASE + 32'h08, 32'd2);
    wr(BASE + 32'h04, 32'h1);
    for (int i = 0; i < 1500; i++) begin
      int sel;
      int ridx;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0] be;
      sel = $urandom_range(0, 99);
      ridx = $urandom_range(0, 5);
      a = BASE + 32'(4 * ridx);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = a + 32'h100;
      d = (ridx == 2) ? 32'($urandom_range(0, 4)) : $urandom;
      if ((ridx == 1) && ($urandom_range(0, 3) != 0)) d[0] = 1'b1;
      if ((ridx == 3) && ($urandom_range(0, 3) != 0)) sel = 50;
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      step(sel < 30, (sel >= 20) && (sel < 60), a, d, be);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
